// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the register-file write port between pipeline writeback
//            and a buffered long-latency producer. Optional write/squash
//            trace is enabled by defining RF_WB_ARB_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] rf_pc,
  input  logic [4:0]  q_addr_1,
  input  logic [4:0]  q_addr_2,
  output logic        q_hit_1,
  output logic        q_hit_2,
  output logic        stall_req,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(STARVE_MAX + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_LIMIT = AW'(STARVE_MAX);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    age_q, age_d;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] rf_pc_q, rf_pc_d;

  logic wb_issue, lu_acc, lu_keep, head_present, head_valid;
  logic head_issue, head_squash, bypass, pop, enq;

  assign lu_ready     = (count_q != CNT_FULL);
  assign busy         = (count_q != '0);
  assign stall_req    = (age_q >= AGE_LIMIT);
  assign wb_issue     = wb_valid && (wb_addr != 5'd0);
  assign lu_acc       = lu_valid && lu_ready;
  // The younger pipeline write to the same register makes this result dead.
  assign lu_keep      = lu_acc && (lu_addr != 5'd0) && !(wb_issue && (lu_addr == wb_addr));
  assign head_present = (count_q != '0);
  assign head_valid   = head_present && valid_q[rd_ptr_q];
  assign head_issue   = !wb_issue && head_valid;
  assign head_squash  = wb_issue && head_valid && (addr_q[rd_ptr_q] == wb_addr);
  assign bypass       = !wb_issue && (count_q == '0) && lu_keep;
  assign pop          = head_present && !wb_issue;
  assign enq          = lu_keep && !bypass;

  always_comb begin
    valid_d = valid_q;
    q_hit_1 = 1'b0;
    q_hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_issue && valid_q[i] && (addr_q[i] == wb_addr)) valid_d[i] = 1'b0;
      if (valid_q[i] && (q_addr_1 != 5'd0) && (addr_q[i] == q_addr_1)) q_hit_1 = 1'b1;
      if (valid_q[i] && (q_addr_2 != 5'd0) && (addr_q[i] == q_addr_2)) q_hit_2 = 1'b1;
    end
    // Pop and enqueue never target the same slot: pop needs count>0, enqueue needs count<DEPTH.
    if (pop) valid_d[rd_ptr_q] = 1'b0;
    if (enq) valid_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (enq) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    count_d = count_q + CW'(enq) - CW'(pop);
  end

  always_comb begin
    age_d = '0;
    if (head_valid && !head_issue && !head_squash)
      age_d = (age_q >= AGE_LIMIT) ? AGE_LIMIT : age_q + 1'b1;
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_pc_d    = rf_pc_q;
    if (wb_issue) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
      rf_pc_d    = wb_pc;
    end else if (head_issue) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_q[rd_ptr_q];
      rf_wdata_d = data_q[rd_ptr_q];
      rf_pc_d    = pc_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lu_addr;
      rf_wdata_d = lu_data;
      rf_pc_d    = lu_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      age_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_pc_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_pc_q    <= rf_pc_d;
    end
  end

  // Payload needs no reset; the valid bits and count qualify it.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= lu_addr;
      data_q[wr_ptr_q] <= lu_data;
      pc_q[wr_ptr_q]   <= lu_pc;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_pc    = rf_pc_q;

`ifdef RF_WB_ARB_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (rf_we_q) $display("pc = %h: x%d = %h", rf_pc_q, rf_waddr_q, rf_wdata_q);
      if (wb_issue) begin
        for (int i = 0; i < DEPTH; i++)
          if (valid_q[i] && (addr_q[i] == wb_addr)) $display("squash x%d pc = %h", addr_q[i], pc_q[i]);
        if (lu_acc && (lu_addr == wb_addr)) $display("squash x%d pc = %h", lu_addr, lu_pc);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rf_wb_arbiter;

  logic        clk, rst;
  logic        wb_valid, lu_valid, lu_ready;
  logic [4:0]  wb_addr, lu_addr, rf_waddr, q_addr_1, q_addr_2;
  logic [31:0] wb_data, wb_pc, lu_data, lu_pc, rf_wdata, rf_pc;
  logic        rf_we, q_hit_1, q_hit_2, stall_req, busy;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data), .lu_pc(lu_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .q_addr_1(q_addr_1), .q_addr_2(q_addr_2), .q_hit_1(q_hit_1), .q_hit_2(q_hit_2),
    .stall_req(stall_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d; wb_pc = 32'h1000 + {27'd0, a};
  endtask

  task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v; lu_addr = a; lu_data = d; lu_pc = 32'h2000 + {27'd0, a};
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, {31'd0, rf_we}, 32'd1);
    check({tag, "_addr"}, {27'd0, rf_waddr}, {27'd0, a});
    check({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0);
    q_addr_1 = 5'd0;
    q_addr_2 = 5'd0;
    #1;
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_pc", rf_pc, 32'd0);
    check("rst_ready", {31'd0, lu_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_hit", {30'd0, q_hit_1, q_hit_2}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Pipeline-only writes
    wb(1'b1, 5'd5, 32'h11);
    tick();
    chk_wr("pipe", 5'd5, 32'h11);
    check("pipe_pc", rf_pc, 32'h1005);
    wb(1'b1, 5'd0, 32'h22);
    tick();
    check("pipe_x0_we", {31'd0, rf_we}, 32'd0);
    wb(1'b0, 5'd0, 32'd0);

    // Bypass into an empty buffer
    lu(1'b1, 5'd7, 32'hAB);
    tick();
    chk_wr("byp", 5'd7, 32'hAB);
    check("byp_pc", rf_pc, 32'h2007);
    check("byp_busy", {31'd0, busy}, 32'd0);
    lu(1'b0, 5'd0, 32'd0);
    tick();
    check("byp_idle_we", {31'd0, rf_we}, 32'd0);

    // Contention and fill
    q_addr_1 = 5'd1;
    q_addr_2 = 5'd2;
    wb(1'b1, 5'd20, 32'h20);
    lu(1'b1, 5'd1, 32'hA1);
    tick();
    chk_wr("fill_wb0", 5'd20, 32'h20);
    check("fill_busy", {31'd0, busy}, 32'd1);
    check("fill_ready1", {31'd0, lu_ready}, 32'd1);
    check("fill_hit_x1", {31'd0, q_hit_1}, 32'd1);
    lu(1'b1, 5'd2, 32'hA2);
    tick();
    check("fill_ready_full", {31'd0, lu_ready}, 32'd0);
    check("fill_hit_x2", {31'd0, q_hit_2}, 32'd1);
    lu(1'b1, 5'd3, 32'hA3);
    q_addr_2 = 5'd3;
    tick();
    check("fill_held_ready", {31'd0, lu_ready}, 32'd0);
    check("fill_x3_not_buf", {31'd0, q_hit_2}, 32'd0);
    chk_wr("fill_wb2", 5'd20, 32'h20);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("drain_x1", 5'd1, 32'hA1);
    check("drain_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    chk_wr("drain_x2", 5'd2, 32'hA2);
    lu(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("drain_x3", 5'd3, 32'hA3);
    check("drain_x3_pc", rf_pc, 32'h2003);
    tick();
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_idle_we", {31'd0, rf_we}, 32'd0);

    // Starvation
    wb(1'b1, 5'd21, 32'h21);
    lu(1'b1, 5'd4, 32'h44);
    tick();
    lu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("starve_stall_%0d", i), {31'd0, stall_req}, (i == 4) ? 32'd1 : 32'd0);
    end
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("starve_x4", 5'd4, 32'h44);
    check("starve_clear", {31'd0, stall_req}, 32'd0);
    check("starve_busy", {31'd0, busy}, 32'd0);

    // Squash
    q_addr_1 = 5'd9;
    wb(1'b1, 5'd22, 32'h22);
    lu(1'b1, 5'd9, 32'h1);
    tick();
    check("sq_hit_before", {31'd0, q_hit_1}, 32'd1);
    lu(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd9, 32'h2);
    tick();
    chk_wr("sq_wb", 5'd9, 32'h2);
    check("sq_hit_after", {31'd0, q_hit_1}, 32'd0);
    check("sq_busy_dead", {31'd0, busy}, 32'd1);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    check("sq_pop_we", {31'd0, rf_we}, 32'd0);
    check("sq_pop_busy", {31'd0, busy}, 32'd0);
    tick();
    check("sq_after_we", {31'd0, rf_we}, 32'd0);

    // Asynchronous reset mid-operation
    wb(1'b1, 5'd23, 32'h23);
    lu(1'b1, 5'd10, 32'hB0);
    tick();
    lu(1'b1, 5'd11, 32'hB1);
    tick();
    lu(1'b0, 5'd0, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_ready", {31'd0, lu_ready}, 32'd0);
    check("mid_we", {31'd0, rf_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we", {31'd0, rf_we}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, lu_ready}, 32'd1);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_we_%0d", i), {31'd0, rf_we}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
